// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// FSM states, opcode/funct values, ALU operations and datapath selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational op/funct decoder: ALU operation, immediate extension mode
// and whether the instruction belongs to the supported subset.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       extop,
    output logic       legal
);

    always_comb begin
        aluop = ALU_ADD;
        extop = 1'b1;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: aluop = ALU_ADD;
                    FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_SLT:  aluop = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_ORI: begin
                aluop = ALU_OR;
                extop = 1'b0;
            end
            OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: begin
                aluop = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM sequencing the shared datapath through fetch,
// decode, execute, memory and writeback, with a timed memory handshake.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] aluop,
    output logic       extop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       reg_write,
    output logic       bus_err,
    output logic       illegal,
    output logic [3:0] state
);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic       req_state;
    logic       timeout;
    logic [2:0] dec_aluop;
    logic       dec_extop;
    logic       dec_legal;

    mc_alu_dec u_dec (
        .op    (op),
        .funct (funct),
        .aluop (dec_aluop),
        .extop (dec_extop),
        .legal (dec_legal)
    );

    // Counter restarts on every path other than an unanswered, unexpired
    // request, so each fresh request (including a FETCH retry) starts at 0.
    assign req_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    assign timeout   = req_state && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));
    assign cnt_nxt   = (req_state && !mem_ready && !timeout) ? cnt + CNT_W'(1) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_REG;
        aluop     = ALU_ADD;
        extop     = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        reg_write = 1'b0;
        bus_err   = 1'b0;
        illegal   = 1'b0;
        state     = cur;

        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                extop     = 1'b1;
                if (!dec_legal) begin
                    illegal = 1'b1;
                    nxt     = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW:     nxt = S_MEM_ADDR;
                        OP_RTYPE:         nxt = S_EXEC_R;
                        OP_ADDIU, OP_ORI: nxt = S_EXEC_I;
                        OP_BEQ:           nxt = S_BRANCH;
                        OP_J:             nxt = S_JUMP;
                        default:          nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                extop     = 1'b1;
                nxt       = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    nxt = S_WB_MEM;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                memtoreg  = 1'b1;
                nxt       = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = dec_aluop;
                nxt       = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                regdst    = 1'b1;
                nxt       = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                extop     = dec_extop;
                aluop     = dec_aluop;
                nxt       = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = zero;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase

        // Reset is combinational on the outputs so a mid-instruction reset
        // suppresses the access in the very cycle it is asserted.
        if (!reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            i_or_d    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = '0;
            alu_src_a = 1'b0;
            alu_src_b = '0;
            aluop     = '0;
            extop     = 1'b0;
            regdst    = 1'b0;
            memtoreg  = 1'b0;
            reg_write = 1'b0;
            bus_err   = 1'b0;
            illegal   = 1'b0;
            state     = '0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl with hand-computed control words.
module tb_mc_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
    logic       extop, regdst, memtoreg, reg_write, bus_err, illegal;
    logic [3:0] state;

    int n_pass  = 0;
    int n_total = 0;

    mc_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .aluop     (aluop),
        .extop     (extop),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .reg_write (reg_write),
        .bus_err   (bus_err),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs are driven 1 time unit after posedge, outputs sampled 1 later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_ok(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f; mem_ready = 1'b1;
        #1;
        check("fetch.state", state, 0);
        check("fetch.mem_req", mem_req, 1);
        check("fetch.i_or_d", i_or_d, 0);
        check("fetch.ir_write", ir_write, 1);
        check("fetch.pc_write", pc_write, 1);
        check("fetch.alu_src_b", alu_src_b, 1);
        tick();
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] exp_op);
        fetch_ok(6'b000000, f);
        #1;
        check("rt.decode.state", state, 1);
        check("rt.decode.alu_src_b", alu_src_b, 3);
        check("rt.decode.illegal", illegal, 0);
        tick(); #1;
        check("rt.exec.state", state, 6);
        check("rt.exec.aluop", aluop, exp_op);
        check("rt.exec.alu_src_a", alu_src_a, 1);
        check("rt.exec.reg_write", reg_write, 0);
        tick(); #1;
        check("rt.wb.state", state, 7);
        check("rt.wb.reg_write", reg_write, 1);
        check("rt.wb.regdst", regdst, 1);
        tick(); #1;
        check("rt.done.state", state, 0);
    endtask

    task automatic run_itype(input logic [5:0] o, input logic [2:0] exp_op, input logic exp_ext);
        fetch_ok(o, 6'b000000);
        tick(); #1;
        check("it.exec.state", state, 8);
        check("it.exec.aluop", aluop, exp_op);
        check("it.exec.extop", extop, exp_ext);
        check("it.exec.alu_src_b", alu_src_b, 2);
        tick(); #1;
        check("it.wb.state", state, 9);
        check("it.wb.reg_write", reg_write, 1);
        check("it.wb.regdst", regdst, 0);
        check("it.wb.memtoreg", memtoreg, 0);
        tick(); #1;
        check("it.done.state", state, 0);
    endtask

    task automatic run_beq(input logic z);
        zero = z;
        fetch_ok(6'b000100, 6'b000000);
        tick(); #1;
        check("beq.state", state, 10);
        check("beq.pc_write", pc_write, {31'd0, z});
        check("beq.pc_src", pc_src, 1);
        check("beq.aluop", aluop, 3'b001);
        tick(); #1;
        check("beq.done.state", state, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick(); #1;
        check("reset.state", state, 0);
        check("reset.mem_req", mem_req, 0);
        check("reset.ir_write", ir_write, 0);
        reset = 1'b1;

        // R-type decode table
        run_rtype(6'b100001, 3'b000);
        run_rtype(6'b100011, 3'b001);
        run_rtype(6'b100100, 3'b010);
        run_rtype(6'b100101, 3'b011);
        run_rtype(6'b101010, 3'b100);

        run_itype(6'b001001, 3'b000, 1'b1);
        run_itype(6'b001101, 3'b011, 1'b0);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        fetch_ok(6'b100011, 6'b000000);
        mem_ready = 1'b1;
        #1;
        check("lw.decode.state", state, 1);
        tick(); #1;
        check("lw.addr.state", state, 2);
        check("lw.addr.alu_src_a", alu_src_a, 1);
        check("lw.addr.alu_src_b", alu_src_b, 2);
        check("lw.addr.mem_req", mem_req, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            check("lw.rd.state", state, 3);
            check("lw.rd.mem_req", mem_req, 1);
            check("lw.rd.i_or_d", i_or_d, 1);
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check("lw.wb.state", state, 4);
        check("lw.wb.reg_write", reg_write, 1);
        check("lw.wb.memtoreg", memtoreg, 1);
        check("lw.wb.regdst", regdst, 0);
        tick(); #1;
        check("lw.done.state", state, 0);

        run_beq(1'b1);
        run_beq(1'b0);

        // j
        fetch_ok(6'b000010, 6'b000000);
        tick(); #1;
        check("j.state", state, 11);
        check("j.pc_src", pc_src, 2);
        check("j.pc_write", pc_write, 1);
        tick(); #1;
        check("j.done.state", state, 0);

        // illegal op and illegal funct
        fetch_ok(6'b111111, 6'b000000);
        #1;
        check("ill.op.illegal", illegal, 1);
        check("ill.op.reg_write", reg_write, 0);
        check("ill.op.pc_write", pc_write, 0);
        check("ill.op.mem_write", mem_write, 0);
        tick(); #1;
        check("ill.op.next", state, 0);
        check("ill.op.pulse", illegal, 0);
        fetch_ok(6'b000000, 6'b000000);
        #1;
        check("ill.fn.illegal", illegal, 1);
        tick(); #1;
        check("ill.fn.next", state, 0);

        // FETCH timeout on the 16th request cycle, then retry succeeds in its 16th
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to.bus_err", bus_err, (i == 15) ? 1 : 0);
            check("to.ir_write", ir_write, 0);
            check("to.pc_write", pc_write, 0);
            check("to.state", state, 0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 15);
            #1;
            check("retry.bus_err", bus_err, 0);
            check("retry.ir_write", ir_write, (i == 15) ? 1 : 0);
            tick();
        end
        #1;
        check("retry.state", state, 1);
        op = 6'b000010; tick(); tick(); #1;
        check("retry.done.state", state, 0);

        // reset during MEM_WR
        fetch_ok(6'b101011, 6'b000000);
        mem_ready = 1'b0;
        tick(); #1;
        check("sw.addr.state", state, 2);
        tick(); #1;
        check("sw.wr.state", state, 5);
        check("sw.wr.mem_req", mem_req, 1);
        check("sw.wr.mem_write", mem_write, 1);
        check("sw.wr.i_or_d", i_or_d, 1);
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        check("rst.mem_req", mem_req, 0);
        check("rst.mem_write", mem_write, 0);
        check("rst.state", state, 0);
        tick(); #1;
        check("rst.held.mem_req", mem_req, 0);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        check("rst.rel.state", state, 0);
        check("rst.rel.mem_req", mem_req, 1);
        check("rst.rel.mem_write", mem_write, 0);
        check("rst.rel.i_or_d", i_or_d, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
